cpm_pcie_rst_seq: RTL and testbench

- Reset and link-up sequencer sitting directly upstream of the CPM5 BMD board-level EP/RP pair.
- Generates the ordered release of the system power-on reset, the CPM5 LPD power-on reset, PCIe PERST (both controllers) and the root-port reset.
- Waits for a debounced link-up on both sides, with a timeout and bounded retry.
- Reports status to the test controller.

---
 rtl/cpm_pcie_rst_seq_pkg.sv | 28 ++
 rtl/cpm_sync_2ff.sv | 23 ++
 rtl/cpm_pcie_rst_seq.sv | 178 +++++++++++++++++
 tb/tb_cpm_pcie_rst_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpm_pcie_rst_seq_pkg.sv
// Shared types and helpers for the CPM5 PCIe reset/link-up sequencer.
// Holds the FSM state encoding and the counter-width check.
package cpm_pcie_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_REL_POR   = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_LINKED    = 3'd4,
        ST_FAIL      = 3'd5
    } rst_state_e;

    function automatic int max4(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Counters compare against (cycles-1), so clog2(cycles) bits suffice.
    function automatic bit cnt_w_ok(int cnt_w, int max_cycles);
        return cnt_w >= $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/cpm_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Resets to 0 so a link never looks up out of reset.
module cpm_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async level through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpm_pcie_rst_seq.sv
// Ordered POR / PERST / RP reset release with debounced link-up,
// link timeout, bounded retry and sticky status for the test controller.
module cpm_pcie_rst_seq
    import cpm_pcie_rst_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 500,
    parameter int unsigned POR_TO_PERST_CYCLES = 16,
    parameter int unsigned LINK_STABLE_CYCLES  = 8,
    parameter int unsigned LINK_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned MAX_RETRY           = 2,
    parameter int unsigned AUTO_START          = 1,
    parameter int unsigned CNT_W               = 24
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       ep_link_up,
    input  logic       rp_link_up,
    output logic       por_n_o,
    output logic       cpm_por_n_o,
    output logic [1:0] perst_n_o,
    output logic       rp_rst_n_o,
    output logic       link_up_o,
    output logic       timeout_o,
    output logic       link_lost_o,
    output logic       fail_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    localparam int MAX_CYC = max4(int'(RST_HOLD_CYCLES),
                                  int'(POR_TO_PERST_CYCLES),
                                  int'(LINK_STABLE_CYCLES),
                                  int'(LINK_TIMEOUT_CYCLES));
    localparam int SW = $clog2(LINK_STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] P2P_LAST  = CNT_W'(POR_TO_PERST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0]    STB_LAST  = SW'(LINK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    generate
        if (!cnt_w_ok(int'(CNT_W), MAX_CYC)) begin : g_cnt_w_chk
            $error("cpm_pcie_rst_seq: CNT_W too small for cycle parameters");
        end
    endgenerate

    rst_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [SW-1:0]    stable;
    logic [SW-1:0]    stb_inc;
    logic             ep_s;
    logic             rp_s;
    logic             both_up;
    logic             stable_hit;
    logic             tmo_hit;
    logic             link_fault;
    logic             retry_ok;

    cpm_sync_2ff u_sync_ep (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (ep_link_up),
        .q     (ep_s)
    );

    cpm_sync_2ff u_sync_rp (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (rp_link_up),
        .q     (rp_s)
    );

    assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign stb_inc    = (&stable) ? stable : stable + SW'(1);
    assign both_up    = ep_s & rp_s;
    assign stable_hit = both_up && (stable == STB_LAST);
    assign tmo_hit    = (cnt == TMO_LAST);
    assign retry_ok   = (retry_cnt_o < RETRY_MAX);

    // Timeout (unless stable completes) or link drop triggers retry/FAIL.
    assign link_fault =
        ((state == ST_WAIT_LINK) && tmo_hit && !stable_hit) ||
        ((state == ST_LINKED) && !both_up);

    assign state_o = state;

    // Sequencer FSM with registered reset and status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            stable      <= '0;
            por_n_o     <= 1'b0;
            cpm_por_n_o <= 1'b0;
            perst_n_o   <= 2'b00;
            rp_rst_n_o  <= 1'b0;
            link_up_o   <= 1'b0;
            timeout_o   <= 1'b0;
            link_lost_o <= 1'b0;
            fail_o      <= 1'b0;
            retry_cnt_o <= 2'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (AUTO_START != 0 || start) begin
                        state <= ST_ASSERT;
                        cnt   <= '0;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        state       <= ST_REL_POR;
                        cnt         <= '0;
                        por_n_o     <= 1'b1;
                        cpm_por_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_REL_POR: begin
                    if (cnt == P2P_LAST) begin
                        state      <= ST_WAIT_LINK;
                        cnt        <= '0;
                        stable     <= '0;
                        perst_n_o  <= 2'b11;
                        rp_rst_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_WAIT_LINK: begin
                    cnt    <= cnt_inc;
                    stable <= both_up ? stb_inc : '0;
                    if (stable_hit) begin
                        state     <= ST_LINKED;
                        link_up_o <= 1'b1;
                    end
                end
                ST_LINKED: begin
                end
                ST_FAIL: begin
                    if (start) begin
                        state       <= ST_ASSERT;
                        cnt         <= '0;
                        retry_cnt_o <= 2'd0;
                        timeout_o   <= 1'b0;
                        link_lost_o <= 1'b0;
                        fail_o      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (link_fault) begin
                cnt         <= '0;
                stable      <= '0;
                link_up_o   <= 1'b0;
                por_n_o     <= 1'b0;
                cpm_por_n_o <= 1'b0;
                perst_n_o   <= 2'b00;
                rp_rst_n_o  <= 1'b0;
                if (state == ST_WAIT_LINK) timeout_o <= 1'b1;
                else link_lost_o <= 1'b1;
                if (retry_ok) begin
                    retry_cnt_o <= retry_cnt_o + 2'd1;
                    state       <= ST_ASSERT;
                end else begin
                    state  <= ST_FAIL;
                    fail_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpm_pcie_rst_seq.sv
// Directed bench for cpm_pcie_rst_seq: nominal, debounce, link loss,
// async reset (instance a) and timeout/retry/FAIL/restart (instance b).
module tb_cpm_pcie_rst_seq;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       rst_a, start_a, ep_a, rp_a;
    logic       por_a, cpm_a, rprst_a, lu_a, tmo_a, lost_a, fail_a;
    logic [1:0] perst_a, retry_a;
    logic [2:0] st_a;

    logic       rst_b, start_b, ep_b, rp_b;
    logic       por_b, cpm_b, rprst_b, lu_b, tmo_b, lost_b, fail_b;
    logic [1:0] perst_b, retry_b;
    logic [2:0] st_b;

    int checks   = 0;
    int failures = 0;
    bit seen_linked;

    cpm_pcie_rst_seq u_a (
        .sys_clk     (sys_clk),
        .sys_rst_n   (rst_a),
        .start       (start_a),
        .ep_link_up  (ep_a),
        .rp_link_up  (rp_a),
        .por_n_o     (por_a),
        .cpm_por_n_o (cpm_a),
        .perst_n_o   (perst_a),
        .rp_rst_n_o  (rprst_a),
        .link_up_o   (lu_a),
        .timeout_o   (tmo_a),
        .link_lost_o (lost_a),
        .fail_o      (fail_a),
        .retry_cnt_o (retry_a),
        .state_o     (st_a)
    );

    cpm_pcie_rst_seq #(.LINK_TIMEOUT_CYCLES(64)) u_b (
        .sys_clk     (sys_clk),
        .sys_rst_n   (rst_b),
        .start       (start_b),
        .ep_link_up  (ep_b),
        .rp_link_up  (rp_b),
        .por_n_o     (por_b),
        .cpm_por_n_o (cpm_b),
        .perst_n_o   (perst_b),
        .rp_rst_n_o  (rprst_b),
        .link_up_o   (lu_b),
        .timeout_o   (tmo_b),
        .link_lost_o (lost_b),
        .fail_o      (fail_b),
        .retry_cnt_o (retry_b),
        .state_o     (st_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        rst_a = 0; start_a = 0; ep_a = 0; rp_a = 0;
        rst_b = 0; start_b = 0; ep_b = 0; rp_b = 0;
        step(3);

        chk("rst_por", por_a, 0);
        chk("rst_cpm", cpm_a, 0);
        chk("rst_perst", perst_a, 0);
        chk("rst_rprst", rprst_a, 0);
        chk("rst_state", st_a, 0);
        chk("rst_linkup", lu_a, 0);
        chk("rst_fail", fail_a, 0);
        chk("rst_retry", retry_a, 0);
        chk("rst_state_b", st_b, 0);

        // Nominal: edge 1 = first posedge after release.
        @(negedge sys_clk);
        rst_a = 1;
        step(500);
        chk("nom_por_500", por_a, 0);
        chk("nom_st_500", st_a, 1);
        step(1);
        chk("nom_por_501", por_a, 1);
        chk("nom_cpm_501", cpm_a, 1);
        chk("nom_st_501", st_a, 2);
        chk("nom_perst_501", perst_a, 0);
        step(15);
        chk("nom_perst_516", perst_a, 0);
        step(1);
        chk("nom_perst_517", perst_a, 3);
        chk("nom_rprst_517", rprst_a, 1);
        chk("nom_st_517", st_a, 3);
        step(999);
        ep_a = 1; rp_a = 1;
        step(9);
        chk("nom_lu_9", lu_a, 0);
        step(1);
        chk("nom_lu_10", lu_a, 1);
        chk("nom_st_linked", st_a, 4);
        chk("nom_retry", retry_a, 0);
        chk("nom_tmo", tmo_a, 0);

        // start in LINKED does nothing.
        start_a = 1;
        step(1);
        start_a = 0;
        step(2);
        chk("ign_start_st", st_a, 4);
        chk("ign_start_lu", lu_a, 1);
        chk("ign_start_retry", retry_a, 0);

        // One-cycle rp drop.
        rp_a = 0;
        step(1);
        rp_a = 1;
        step(1);
        chk("loss_lu_e2", lu_a, 1);
        step(1);
        chk("loss_lu", lu_a, 0);
        chk("loss_lost", lost_a, 1);
        chk("loss_retry", retry_a, 1);
        chk("loss_st", st_a, 1);
        chk("loss_perst", perst_a, 0);

        // Debounce: ep 5 high / 1 low, rp high.
        seen_linked = 0;
        for (int r = 0; r < 100; r++) begin
            ep_a = 1;
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (st_a == 3'd4) seen_linked = 1;
            end
            ep_a = 0;
            step(1);
            if (st_a == 3'd4) seen_linked = 1;
        end
        chk("deb_never_linked", seen_linked, 0);
        chk("deb_st_wait", st_a, 3);
        chk("deb_lu", lu_a, 0);
        ep_a = 1;
        step(9);
        chk("deb_lu_9", lu_a, 0);
        step(1);
        chk("deb_lu_10", lu_a, 1);
        chk("deb_st_linked", st_a, 4);

        // Drop both, re-sequence into WAIT_LINK, then async reset.
        ep_a = 0; rp_a = 0;
        step(3);
        chk("drop_retry2", retry_a, 2);
        chk("drop_st", st_a, 1);
        step(517);
        chk("pre_arst_st", st_a, 3);
        #3;
        rst_a = 0;
        #1;
        chk("arst_st", st_a, 0);
        chk("arst_perst", perst_a, 0);
        chk("arst_por", por_a, 0);
        chk("arst_rprst", rprst_a, 0);
        chk("arst_retry", retry_a, 0);
        chk("arst_lost", lost_a, 0);
        @(negedge sys_clk);
        rst_a = 1;
        step(500);
        chk("rerun_por_500", por_a, 0);
        step(1);
        chk("rerun_por_501", por_a, 1);
        chk("rerun_st_501", st_a, 2);

        // Timeout/retry/FAIL on instance b (64-cycle timeout).
        @(negedge sys_clk);
        rst_b = 1;
        step(580);
        chk("t1_st_580", st_b, 3);
        chk("t1_tmo_580", tmo_b, 0);
        chk("t1_perst_580", perst_b, 3);
        step(1);
        chk("t1_tmo", tmo_b, 1);
        chk("t1_retry", retry_b, 1);
        chk("t1_st", st_b, 1);
        chk("t1_perst", perst_b, 0);
        step(499);
        chk("t2_por_1080", por_b, 0);
        step(1);
        chk("t2_por_1081", por_b, 1);
        step(79);
        chk("t2_st_1160", st_b, 3);
        step(1);
        chk("t2_retry", retry_b, 2);
        chk("t2_st", st_b, 1);
        step(579);
        chk("t3_st_1740", st_b, 3);
        chk("t3_fail_1740", fail_b, 0);
        step(1);
        chk("t3_st_fail", st_b, 5);
        chk("t3_fail", fail_b, 1);
        chk("t3_retry", retry_b, 2);
        chk("t3_perst", perst_b, 0);
        chk("t3_por", por_b, 0);
        chk("t3_tmo", tmo_b, 1);

        // Restart from FAIL.
        start_b = 1;
        step(1);
        start_b = 0;
        chk("rs_fail", fail_b, 0);
        chk("rs_tmo", tmo_b, 0);
        chk("rs_retry", retry_b, 0);
        chk("rs_st", st_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
